// File: rtl/tdt_gated_clk_ctrl_if.sv
// Signal bundle between the clock-enable controller and its surroundings.
// The master side drives the enable terms; the slave (the controller) returns enables and idle status.
interface tdt_gated_clk_ctrl_if #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 4
);
  logic              global_en;
  logic [CH_NUM-1:0] module_en;
  logic [CH_NUM-1:0] local_en;
  logic [CH_NUM-1:0] external_en;
  logic              pad_yy_icg_scan_en;
  logic [CNT_W-1:0]  hold_cyc;
  logic [CH_NUM-1:0] ch_clk_en;
  logic [CH_NUM-1:0] ch_idle;
  logic              all_idle;

  modport master (
    output global_en, module_en, local_en, external_en, pad_yy_icg_scan_en, hold_cyc,
    input  ch_clk_en, ch_idle, all_idle
  );

  modport slave (
    input  global_en, module_en, local_en, external_en, pad_yy_icg_scan_en, hold_cyc,
    output ch_clk_en, ch_idle, all_idle
  );
endinterface

// File: rtl/tdt_gated_clk_ctrl.sv
// Multi-channel clock-enable controller: per-channel OFF/ON/HOLD FSM keeps the ICG enable
// asserted for hold_cyc idle cycles after a request drops, so short gaps never toggle the gate.
module tdt_gated_clk_ctrl #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 4
) (
  input logic                 forever_cpuclk,
  input logic                 cpurst_b,
  tdt_gated_clk_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_q [CH_NUM];
  state_t            state_d [CH_NUM];
  logic [CNT_W-1:0]  cnt_q   [CH_NUM];
  logic [CNT_W-1:0]  cnt_d   [CH_NUM];
  logic [CH_NUM-1:0] req;
  logic [CH_NUM-1:0] busy;

  // external_en is a force-on and deliberately bypasses global_en
  assign req = ({CH_NUM{bus.global_en}} & (bus.module_en | bus.local_en)) | bus.external_en;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // hold_cyc is sampled only on ON->HOLD; the counter then only counts down and parks at 0
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (req[i]) state_d[i] = ST_ON;
        end
        ST_ON: begin
          if (!req[i]) begin
            if (bus.hold_cyc == '0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = bus.hold_cyc - CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (req[i])               state_d[i] = ST_ON;
          else if (cnt_q[i] == '0)  state_d[i] = ST_OFF;
          else                      cnt_d[i]   = cnt_q[i] - CNT_W'(1);
        end
        default: state_d[i] = ST_OFF;
      endcase
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      busy[i] = (state_q[i] != ST_OFF);
    end
  end

  // scan OR is the only combinational path into the gate enables
  assign bus.ch_clk_en = busy | {CH_NUM{bus.pad_yy_icg_scan_en}};
  assign bus.ch_idle   = ~busy;
  assign bus.all_idle  = &bus.ch_idle;

endmodule
